// File: rtl/debug_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : debug_word_serializer
//  Purpose  : Splits full-width debug words (PC, clock count, register and
//             memory dumps) into DATA_BITS-wide bytes, LSB byte first, and
//             hands them one at a time to a UART transmitter using a
//             start-pulse / done-pulse handshake. A one-word skid buffer
//             lets the producer run one word ahead of the serializer. A
//             per-byte watchdog aborts a word if the transmitter stops
//             answering.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   1          design clock (UART clock domain)
//    reset            in   1          asynchronous reset, active low
//    i_word_valid     in   1          producer offers i_word
//    i_word           in   NBITS      word to serialize
//    o_word_ready     out  1          a word is accepted this cycle if valid
//    i_uart_tx_done   in   1          transmitter finished the current byte
//    o_uart_tx_ready  out  1          one-cycle start pulse to transmitter
//    o_uart_tx_data   out  DATA_BITS  byte being transmitted
//    o_word_done      out  1          pulse: last byte of a word completed
//    o_busy           out  1          word buffered or being serialized
//    o_error          out  1          sticky watchdog-abort flag
// ----------------------------------------------------------------------------
//  Parameter constraints: NBITS is an integer multiple of DATA_BITS and
//  TIMEOUT is at least 2.
// ============================================================================
module debug_word_serializer #(
    parameter int NBITS     = 32,
    parameter int DATA_BITS = 8,
    parameter int TIMEOUT   = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_word_valid,
    input  logic [NBITS-1:0]     i_word,
    output logic                 o_word_ready,
    input  logic                 i_uart_tx_done,
    output logic                 o_uart_tx_ready,
    output logic [DATA_BITS-1:0] o_uart_tx_data,
    output logic                 o_word_done,
    output logic                 o_busy,
    output logic                 o_error
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int BYTES = NBITS / DATA_BITS;
    // A single-byte word still gets a 1-bit index so the logic stays uniform.
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    // The watchdog never exceeds TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    state_t                 state_q,     state_d;
    logic [NBITS-1:0]       buf_q,       buf_d;
    logic                   buf_full_q,  buf_full_d;
    logic [NBITS-1:0]       shift_q,     shift_d;
    logic [IDX_W-1:0]       idx_q,       idx_d;
    logic [WD_W-1:0]        wd_q,        wd_d;
    logic                   tx_ready_q,  tx_ready_d;
    logic [DATA_BITS-1:0]   tx_data_q,   tx_data_d;
    logic                   word_done_q, word_done_d;
    logic                   error_q,     error_d;
    // Holds o_word_ready low while reset is asserted and rises on the first
    // clock after release, so every output reads zero during reset.
    logic                   out_en_q,    out_en_d;

    logic                   accept;
    logic [NBITS-1:0]       shift_next;

    assign accept     = i_word_valid && o_word_ready;
    assign shift_next = shift_q >> DATA_BITS;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        wd_d        = wd_q;
        tx_ready_d  = 1'b0;
        tx_data_d   = tx_data_q;
        word_done_d = 1'b0;
        error_d     = error_q;
        out_en_d    = 1'b1;

        // Skid buffer capture. Acceptance requires an empty buffer, so it can
        // never coincide with IDLE draining the buffer below.
        if (accept) begin
            buf_d      = i_word;
            buf_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (buf_full_q) begin
                    shift_d    = buf_q;
                    buf_full_d = 1'b0;
                    idx_d      = '0;
                    wd_d       = '0;
                    state_d    = S_START;
                    // Start pulse and byte are registered on entry to START.
                    tx_ready_d = 1'b1;
                    tx_data_d  = buf_q[DATA_BITS-1:0];
                end
            end

            S_START: begin
                // The watchdog measures cycles since the start pulse, so the
                // START cycle itself is counted.
                wd_d    = wd_q + WD_ONE;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // Done takes priority over watchdog expiry in the same cycle.
                if (i_uart_tx_done) begin
                    if (idx_q == IDX_LAST) begin
                        word_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        shift_d    = shift_next;
                        idx_d      = idx_q + IDX_ONE;
                        wd_d       = '0;
                        state_d    = S_START;
                        tx_ready_d = 1'b1;
                        tx_data_d  = shift_next[DATA_BITS-1:0];
                    end
                end else if (wd_q == WD_LAST) begin
                    // Abort: remaining bytes of this word are dropped.
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            shift_q     <= '0;
            idx_q       <= '0;
            wd_q        <= '0;
            tx_ready_q  <= 1'b0;
            tx_data_q   <= '0;
            word_done_q <= 1'b0;
            error_q     <= 1'b0;
            out_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            wd_q        <= wd_d;
            tx_ready_q  <= tx_ready_d;
            tx_data_q   <= tx_data_d;
            word_done_q <= word_done_d;
            error_q     <= error_d;
            out_en_q    <= out_en_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all derived from registers only)
    // ------------------------------------------------------------------------
    assign o_word_ready    = out_en_q && !buf_full_q;
    assign o_uart_tx_ready = tx_ready_q;
    assign o_uart_tx_data  = tx_data_q;
    assign o_word_done     = word_done_q;
    assign o_busy          = buf_full_q || (state_q != S_IDLE);
    assign o_error         = error_q;

endmodule

`default_nettype wire

// File: doc/debug_word_serializer.md
Name: debug_word_serializer

Overview:
- Downstream of the MIPS debug unit and upstream of the UART transmit interface.
- Takes the debug unit's full-width words (PC, clock count, register and memory dumps) and sends each one as DATA_BITS-wide bytes, LSB byte first.
- Handshakes byte-by-byte with the UART transmitter and holds one word in a skid buffer so the producer can run ahead by one word.
- Has a watchdog that aborts a word if the transmitter stops answering.

Parameters:
- NBITS, 32, width of an input word; must be an integer multiple of DATA_BITS.
- DATA_BITS, 8, width of one UART byte.
- TIMEOUT, 100000, maximum number of clk cycles to wait for i_uart_tx_done per byte before aborting.

Ports:
- clk  in  1  design clock (same domain as the UART interfaces).
- reset  in  1  asynchronous, active-low reset.
- i_word_valid  in  1  producer has a word on i_word.
- i_word  in  NBITS  word to send.
- o_word_ready  out  1  a word can be accepted this cycle.
- i_uart_tx_done  in  1  one-cycle pulse from the UART transmitter: byte finished.
- o_uart_tx_ready  out  1  one-cycle start pulse to the UART transmitter.
- o_uart_tx_data  out  DATA_BITS  byte to transmit; stable from the start pulse until done.
- o_word_done  out  1  one-cycle pulse when the last byte of a word has completed.
- o_busy  out  1  a word is in the skid buffer or being serialized.
- o_error  out  1  sticky flag: a watchdog abort has occurred.

Behaviour:
- Derived constant: BYTES = NBITS/DATA_BITS. Byte index width is clog2(BYTES); with a single byte, a 1-bit index is used.
- Reset (reset=0, asynchronous) drives every output and register to zero:
  - state is IDLE; skid buffer is empty.
  - o_uart_tx_ready=0, o_uart_tx_data=0, o_word_done=0, o_error=0, o_busy=0.
  - o_word_ready=1 once reset is released.
- Input handshake:
  - o_word_ready = !buf_full (registered state, no combinational path from i_word_valid).
  - A word is accepted on a rising edge where i_word_valid && o_word_ready; i_word is captured into the skid buffer and buf_full is set.
- State machine (IDLE, START, WAIT):
  - IDLE: if buf_full, load the shift register from the buffer, clear buf_full, clear the byte index, clear the watchdog, go to START. Otherwise stay in IDLE.
  - START: o_uart_tx_ready=1 for exactly this cycle. o_uart_tx_data = shift[DATA_BITS-1:0]. Go to WAIT.
  - WAIT: the watchdog increments each cycle.
    - If i_uart_tx_done and index==BYTES-1: pulse o_word_done next cycle, go to IDLE.
    - If i_uart_tx_done and index<BYTES-1: shift right by DATA_BITS, index+1, clear the watchdog, go to START.
    - If the watchdog reaches TIMEOUT-1 without done: set o_error, discard the remaining bytes, go to IDLE. o_word_done does not pulse.
- o_uart_tx_data is registered; it updates only on entry to START and holds through WAIT.
- Latency:
  - Word accepted at edge N: buffer full during cycle N+1.
  - First o_uart_tx_ready pulse during cycle N+2.
  - After each i_uart_tx_done (not the last byte), the next start pulse comes the following cycle.
- Skid buffer:
  - A new word may be accepted at any time while the serializer is in START or WAIT.
  - The buffer is freed in IDLE, so o_word_ready rises the cycle after IDLE loads it.
  - Back-to-back words: IDLE is visited for exactly one cycle between words.
- i_uart_tx_done is ignored in IDLE and START (spurious pulses have no effect).
- Simultaneous i_uart_tx_done and watchdog expiry in the same WAIT cycle: done wins, no error.
- o_busy = buf_full || state!=IDLE.
- o_error is cleared only by reset.
- Reset mid-word: everything clears immediately and the partial word is lost. o_uart_tx_ready must not glitch high on reset release.

Test Plan:
- Single word: i_word=0xA1B2C3D4 accepted at edge 0, UART model answers done 10 cycles after each start.
  -> start pulses carry 0xD4, 0xC3, 0xB2, 0xA1 in order; first start in cycle 2; o_word_done pulses once after the 4th done; o_busy returns to 0.
- Back-to-back: offer 0x11223344 then 0x55667788 with i_word_valid held high.
  -> second word is accepted while the first is serializing; third offer is stalled (o_word_ready=0) until the buffer drains; 8 bytes 44,33,22,11,88,77,66,55 appear; exactly one IDLE cycle between words.
- Watchdog: TIMEOUT=20, i_word=0xDEADBEEF, UART model answers only the first byte.
  -> 0xEF sent, 0xBE started, no further starts; o_error=1 twenty cycles after the 0xBE start; no o_word_done; the next word is serialized normally and o_error stays 1.
- Spurious done: pulse i_uart_tx_done in IDLE and in the START cycle.
  -> no state change, no byte skipped; the byte sequence is unchanged versus the clean run.
- Reset mid-word: assert reset during WAIT of byte 2 of 0xCAFEF00D, release, then send 0x01020304.
  -> all outputs are 0 during reset; after release only 04,03,02,01 are transmitted; o_error=0.
- Done/timeout collision: TIMEOUT=20, drive done exactly in the expiry cycle.
  -> byte counts as sent, o_error stays 0, serialization continues.
